pc_gen: RTL and testbench
=========================

Name: pc_gen

Overview:
- Parametrised fetch-stage program-counter generator. Successor to the fixed 32-bit pc+4/ALU-select PC register.
- Drives instruction-memory fetch requests with a valid/ready handshake, honours decode stall, and accepts prioritised trap and branch/jump redirects.
- Checks target alignment and reports misaligned redirects as a fault. Sits between the execute/trap units and the instruction memory port.

Parameters:
- XLEN, 32: address/PC width in bits.
- RESET_ADDR, 0 (XLEN bits): PC value loaded on reset.
- IALIGN, 32: minimum instruction alignment in bits. Legal values are 32 (4-byte) and 16 (2-byte, compressed-capable).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  decode backpressure; holds PC and suppresses new requests.
- redirect_valid  in  1  branch/jump redirect request, single cycle.
- redirect_target  in  XLEN  branch/jump target.
- trap_valid  in  1  trap/exception redirect, single cycle.
- trap_target  in  XLEN  trap vector address.
- req_valid  out  1  fetch request valid.
- req_addr  out  XLEN  fetch address (current PC).
- req_ready  in  1  instruction memory accepts request.
- misalign_exc  out  1  one-cycle pulse: misaligned redirect target.
- misalign_addr  out  XLEN  offending target, held until next fault.
- pc  out  XLEN  current PC register.

Behaviour:
- Clock and reset: clk is the clock; reset is asynchronous, active-high.
- Reset values: pc=RESET_ADDR, state=BOOT, req_valid=0, misalign_exc=0, misalign_addr=0.
- Reset asserted mid-operation aborts everything immediately; no pending redirect survives.
- States:
  - BOOT: one cycle after reset release, req_valid=0. Then go to RUN unconditionally, unless trap_valid=1 that cycle, which loads trap_target and still enters RUN.
  - RUN: req_valid = !stall; req_addr = pc.
  - FAULT: req_valid=0; pc holds. Exit to RUN only on trap_valid; redirect_valid is ignored in FAULT.
- Handshake:
  - fire = req_valid & req_ready.
  - On fire without redirect, pc <= pc + 4, modulo 2^XLEN; 0xFFFF_FFFC wraps to 0.
  - With no fire and no redirect, pc holds, so req_addr is stable while req_valid=1 and req_ready=0.
  - The interface is flush-permitted: a redirect may change req_addr while a request is unaccepted.
- Redirect priority: trap_valid > redirect_valid > sequential. Simultaneous trap and redirect loads the trap target; the redirect is dropped.
- Redirects take effect at the next clock edge regardless of stall or req_ready. The new pc is presented the following cycle.
- A request that fires in the same cycle as a redirect is treated as wrong-path. Downstream discards it; pc_gen does not track it.
- Alignment check, redirect_target only:
  - IALIGN=32: target[1:0] must be 0.
  - IALIGN=16: target[0] must be 0.
  - Misaligned target: pc does not change; misalign_exc=1 for exactly one cycle (registered, the cycle after detection); misalign_addr=target; state goes to FAULT.
- trap_target is never faulted. Its low bits are forced to zero ([1:0] for IALIGN=32, [0] for IALIGN=16) before loading.
- stall: in RUN, stall=1 forces req_valid=0 and holds pc. Stall has no effect on redirects or state transitions.
- Latency: redirect at edge N means req_addr=target in cycle N+1 when stall=0.

Test Plan:
- Reset release, stall=0, req_ready=1, RESET_ADDR=0x1000: req_valid=0 for 1 cycle (BOOT), then req_addr sequence 0x1000, 0x1004, 0x1008.
- req_ready=0 for 3 cycles at pc=0x1008: req_addr stays 0x1008. req_ready=1: next addr is 0x100C. Repeat with stall=1: req_valid=0 and pc holds.
- redirect_valid with target 0x2000 and trap_valid with target 0x80000103 in the same cycle: next req_addr=0x80000100. A lone redirect to 0x2000 during stall=1 gives pc=0x2000 after stall drops.
- IALIGN=32, redirect to 0x2002: misalign_exc pulses once, misalign_addr=0x2002, pc unchanged, req_valid=0. A later redirect_valid is ignored. trap_valid to 0x300 resumes with req_addr=0x300. With IALIGN=16, 0x2002 is accepted.
- pc=0xFFFFFFFC, fire: pc wraps to 0x00000000.
- Assert reset while in FAULT, or mid-stall with req_ready=0: outputs return to reset values asynchronously and pc=RESET_ADDR.

Source files
------------

// File: rtl/pc_gen.sv
// Fetch-stage program-counter generator: sequential fetch with valid/ready,
// decode stall, prioritised trap/branch redirects and misaligned-target faulting.
module pc_gen #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_ADDR = '0,
  parameter int              IALIGN     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_target,
  output logic            req_valid,
  output logic [XLEN-1:0] req_addr,
  input  logic            req_ready,
  output logic            misalign_exc,
  output logic [XLEN-1:0] misalign_addr,
  output logic [XLEN-1:0] pc
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Bits that must be zero in any legal instruction address.
  localparam logic [XLEN-1:0] LOW_BITS = (IALIGN == 16) ? XLEN'(1) : XLEN'(3);

  state_t          state, state_next;
  logic [XLEN-1:0] pc_q, pc_next;
  logic [XLEN-1:0] maddr_q, maddr_next;
  logic            exc_q, exc_next;

  logic            fire;
  logic            target_misaligned;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] seq_pc;

  assign req_valid         = (state == RUN) && !stall;
  assign fire              = req_valid && req_ready;
  assign target_misaligned = |(redirect_target & LOW_BITS);
  assign trap_pc           = trap_target & ~LOW_BITS;
  assign seq_pc            = pc_q + XLEN'(4);

  assign req_addr      = pc_q;
  assign pc            = pc_q;
  assign misalign_exc  = exc_q;
  assign misalign_addr = maddr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= BOOT;
      pc_q    <= RESET_ADDR;
      maddr_q <= '0;
      exc_q   <= 1'b0;
    end else begin
      state   <= state_next;
      pc_q    <= pc_next;
      maddr_q <= maddr_next;
      exc_q   <= exc_next;
    end
  end

  // Trap beats redirect beats sequential; a fire coinciding with a redirect is wrong-path.
  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    maddr_next = maddr_q;
    exc_next   = 1'b0;
    case (state)
      BOOT: begin
        state_next = RUN;
        if (trap_valid) begin
          pc_next = trap_pc;
        end
      end
      RUN: begin
        if (trap_valid) begin
          pc_next = trap_pc;
        end else if (redirect_valid) begin
          if (target_misaligned) begin
            state_next = FAULT;
            exc_next   = 1'b1;
            maddr_next = redirect_target;
          end else begin
            pc_next = redirect_target;
          end
        end else if (fire) begin
          pc_next = seq_pc;
        end
      end
      FAULT: begin
        if (trap_valid) begin
          state_next = RUN;
          pc_next    = trap_pc;
        end
      end
      default: begin
        state_next = BOOT;
        pc_next    = RESET_ADDR;
      end
    endcase
  end

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed cycles with expected outputs queued
// as stimulus is applied and compared when the cycle's outputs settle.
module tb_pc_gen;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic        req_ready;

  logic        req_valid,  req_valid16;
  logic [31:0] req_addr,   req_addr16;
  logic        misalign_exc, misalign_exc16;
  logic [31:0] misalign_addr, misalign_addr16;
  logic [31:0] pc, pc16;

  int compared   = 0;
  int mismatched = 0;
  int step_no    = 0;

  typedef struct {
    int          step;
    logic        valid;
    logic [31:0] addr;
    logic        exc;
    logic [31:0] maddr;
    logic        chk16;
    logic [31:0] addr16;
  } exp_t;

  exp_t sb[$];

  pc_gen #(.XLEN(32), .RESET_ADDR(32'h0000_1000), .IALIGN(32)) dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .misalign_exc(misalign_exc), .misalign_addr(misalign_addr), .pc(pc)
  );

  pc_gen #(.XLEN(32), .RESET_ADDR(32'h0000_1000), .IALIGN(16)) dut16 (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_target(trap_target),
    .req_valid(req_valid16), .req_addr(req_addr16), .req_ready(req_ready),
    .misalign_exc(misalign_exc16), .misalign_addr(misalign_addr16), .pc(pc16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic compareCycle();
    exp_t e;
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    checkOutput($sformatf("s%0d_req_valid", e.step), {31'd0, req_valid}, {31'd0, e.valid});
    checkOutput($sformatf("s%0d_req_addr", e.step), req_addr, e.addr);
    checkOutput($sformatf("s%0d_pc", e.step), pc, e.addr);
    checkOutput($sformatf("s%0d_misalign_exc", e.step), {31'd0, misalign_exc}, {31'd0, e.exc});
    checkOutput($sformatf("s%0d_misalign_addr", e.step), misalign_addr, e.maddr);
    if (e.chk16) begin
      checkOutput($sformatf("s%0d_ialign16_addr", e.step), req_addr16, e.addr16);
      checkOutput($sformatf("s%0d_ialign16_exc", e.step), {31'd0, misalign_exc16}, 32'd0);
    end
  endtask

  task automatic pushExpect(input logic ev, input logic [31:0] ea, input logic ee,
                            input logic [31:0] em, input logic c16, input logic [31:0] ea16);
    exp_t e;
    step_no++;
    e.step   = step_no;
    e.valid  = ev;
    e.addr   = ea;
    e.exc    = ee;
    e.maddr  = em;
    e.chk16  = c16;
    e.addr16 = ea16;
    sb.push_back(e);
  endtask

  // Called just after a rising edge; drives one cycle of inputs, then checks that cycle's outputs.
  task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rt,
                               input logic tv, input logic [31:0] tt, input logic rdy,
                               input logic ev, input logic [31:0] ea, input logic ee,
                               input logic [31:0] em, input logic c16, input logic [31:0] ea16);
    stall           = st;
    redirect_valid  = rv;
    redirect_target = rt;
    trap_valid      = tv;
    trap_target     = tt;
    req_ready       = rdy;
    pushExpect(ev, ea, ee, em, c16, ea16);
    @(negedge clk);
    compareCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    stall           = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    trap_valid      = 1'b0;
    trap_target     = '0;
    req_ready       = 1'b1;

    #3;
    pushExpect(1'b0, 32'h1000, 1'b0, 32'h0, 1'b1, 32'h1000);
    compareCycle();
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;

    //             st  rv  rt            tv  tt            rdy   ev  ea            ee  em            c16 ea16
    applyStimulus(0, 0, 32'h0,        0, 32'h0,        1,    0, 32'h1000,     0, 32'h0,     1, 32'h1000);
    applyStimulus(0, 0, 32'h0,        0, 32'h0,        1,    1, 32'h1000,     0, 32'h0,     1, 32'h1000);
    applyStimulus(0, 0, 32'h0,        0, 32'h0,        1,    1, 32'h1004,     0, 32'h0,     1, 32'h1004);
    for (int i = 0; i < 3; i++)
      applyStimulus(0, 0, 32'h0,      0, 32'h0,        0,    1, 32'h1008,     0, 32'h0,     1, 32'h1008);
    applyStimulus(0, 0, 32'h0,        0, 32'h0,        1,    1, 32'h1008,     0, 32'h0,     1, 32'h1008);
    applyStimulus(1, 0, 32'h0,        0, 32'h0,        1,    0, 32'h100C,     0, 32'h0,     1, 32'h100C);
    applyStimulus(1, 0, 32'h0,        0, 32'h0,        1,    0, 32'h100C,     0, 32'h0,     1, 32'h100C);
    applyStimulus(0, 0, 32'h0,        0, 32'h0,        1,    1, 32'h100C,     0, 32'h0,     1, 32'h100C);
    // Trap and redirect together while a request fires: trap wins, low bits cleared per IALIGN.
    applyStimulus(0, 1, 32'h2000,     1, 32'h80000103, 1,    1, 32'h1010,     0, 32'h0,     1, 32'h1010);
    applyStimulus(0, 0, 32'h0,        0, 32'h0,        0,    1, 32'h80000100, 0, 32'h0,     1, 32'h80000102);
    applyStimulus(1, 1, 32'h2000,     0, 32'h0,        0,    0, 32'h80000100, 0, 32'h0,     1, 32'h80000102);
    applyStimulus(1, 0, 32'h0,        0, 32'h0,        0,    0, 32'h2000,     0, 32'h0,     1, 32'h2000);
    applyStimulus(0, 0, 32'h0,        0, 32'h0,        0,    1, 32'h2000,     0, 32'h0,     1, 32'h2000);
    // Halfword target: faults at IALIGN=32, accepted at IALIGN=16.
    applyStimulus(0, 1, 32'h2002,     0, 32'h0,        0,    1, 32'h2000,     0, 32'h0,     1, 32'h2000);
    applyStimulus(0, 0, 32'h0,        0, 32'h0,        1,    0, 32'h2000,     1, 32'h2002,  1, 32'h2002);
    applyStimulus(0, 1, 32'h3000,     0, 32'h0,        1,    0, 32'h2000,     0, 32'h2002,  0, 32'h0);
    applyStimulus(0, 0, 32'h0,        1, 32'h300,      1,    0, 32'h2000,     0, 32'h2002,  0, 32'h0);
    applyStimulus(0, 0, 32'h0,        0, 32'h0,        1,    1, 32'h300,      0, 32'h2002,  0, 32'h0);
    applyStimulus(0, 1, 32'hFFFFFFFC, 0, 32'h0,        1,    1, 32'h304,      0, 32'h2002,  0, 32'h0);
    applyStimulus(0, 0, 32'h0,        0, 32'h0,        1,    1, 32'hFFFFFFFC, 0, 32'h2002,  0, 32'h0);
    applyStimulus(0, 0, 32'h0,        0, 32'h0,        0,    1, 32'h0,        0, 32'h2002,  0, 32'h0);
    applyStimulus(0, 1, 32'h5001,     0, 32'h0,        0,    1, 32'h0,        0, 32'h2002,  0, 32'h0);
    applyStimulus(0, 0, 32'h0,        0, 32'h0,        0,    0, 32'h0,        1, 32'h5001,  0, 32'h0);

    // Asynchronous reset while in FAULT, mid-cycle.
    #2;
    reset = 1'b1;
    #1;
    pushExpect(1'b0, 32'h1000, 1'b0, 32'h0, 1'b1, 32'h1000);
    compareCycle();
    @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus(0, 0, 32'h0,        0, 32'h0,        1,    0, 32'h1000,     0, 32'h0,     1, 32'h1000);
    applyStimulus(0, 0, 32'h0,        0, 32'h0,        1,    1, 32'h1000,     0, 32'h0,     1, 32'h1000);
    applyStimulus(0, 0, 32'h0,        0, 32'h0,        0,    1, 32'h1004,     0, 32'h0,     1, 32'h1004);

    // Asynchronous reset during a stall with the memory not ready.
    stall     = 1'b1;
    req_ready = 1'b0;
    #1;
    pushExpect(1'b0, 32'h1004, 1'b0, 32'h0, 1'b1, 32'h1004);
    compareCycle();
    reset = 1'b1;
    #1;
    pushExpect(1'b0, 32'h1000, 1'b0, 32'h0, 1'b1, 32'h1000);
    compareCycle();
    @(posedge clk);
    #1;
    reset = 1'b0;
    stall = 1'b0;
    applyStimulus(0, 0, 32'h0,        0, 32'h0,        1,    0, 32'h1000,     0, 32'h0,     1, 32'h1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
